// File: rtl/mem_pkg.sv
// Shared constants for the load/store unit: RISC-V load/store funct3
// encodings, the trap cause codes it reports, and dmem byte-lane masks.
package mem_pkg;

  // Load/store width encodings (funct3)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Trap cause codes
  localparam logic [3:0] EXC_ILLEGAL     = 4'd2;
  localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
  localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
  localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
  localparam logic [3:0] EXC_ST_FAULT    = 4'd7;

  // dmem byte-lane masks
  localparam logic [7:0] SEL_B = 8'h01;
  localparam logic [7:0] SEL_H = 8'h03;
  localparam logic [7:0] SEL_W = 8'h0F;
  localparam logic [7:0] SEL_D = 8'hFF;

  // Access size (low two funct3 bits) to byte-lane mask.
  function automatic logic [7:0] sel_from_size(input logic [1:0] size);
    logic [7:0] sel;
    case (size)
      2'b00:   sel = SEL_B;
      2'b01:   sel = SEL_H;
      2'b10:   sel = SEL_W;
      default: sel = SEL_D;
    endcase
    return sel;
  endfunction

  // Loads have no 111 encoding; stores have no unsigned variants.
  function automatic logic f3_illegal(input logic       is_load,
                                      input logic       is_store,
                                      input logic [2:0] f3);
    return (is_load && (f3 == 3'b111)) || (is_store && f3[2]);
  endfunction

endpackage

// File: rtl/mem_lsu_load_fmt.sv
// Formats raw dmem read data (already shifted to bit 0, zero-extended)
// into the architectural register value for each load width.
module lsu_load_fmt
  import mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_data,
  output logic [XLEN-1:0] o_data
);

  // Sign- or zero-extend from the access width selected by funct3
  always_comb begin
    o_data = '0;
    case (i_funct3)
      F3_B:    o_data = {{(XLEN-8){i_data[7]}},   i_data[7:0]};
      F3_H:    o_data = {{(XLEN-16){i_data[15]}}, i_data[15:0]};
      F3_W:    o_data = {{(XLEN-32){i_data[31]}}, i_data[31:0]};
      F3_D:    o_data = i_data;
      F3_BU:   o_data = {{(XLEN-8){1'b0}},  i_data[7:0]};
      F3_HU:   o_data = {{(XLEN-16){1'b0}}, i_data[15:0]};
      F3_WU:   o_data = {{(XLEN-32){1'b0}}, i_data[31:0]};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Two-stage load/store unit. Stage A registers the accepted request and
// drives dmem; stage B holds the formatted response for writeback/trap.
//
// Handshake contract: a transfer happens on a rising edge where valid and
// ready are both high; valid may not depend on ready, and the payload is
// held stable while valid is high and ready is low. flush cancels any
// transfer into stage A and empties both stages at that edge.
module mem_lsu
  import mem_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_load,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [REG_AW-1:0] req_rd,
  input  logic [XLEN-1:0]   req_pc,
  output logic              we_dmem,
  output logic              is_LOAD,
  output logic [7:0]        dmem_word_sel,
  output logic [XLEN-1:0]   r_dmem_addr,
  output logic [XLEN-1:0]   w_dmem_data,
  input  logic [XLEN-1:0]   dmem_data,
  input  logic              dmem_exc_en,
  input  logic [3:0]        dmem_exc_code,
  input  logic [XLEN-1:0]   dmem_exc_val,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_wb_en,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic [REG_AW-1:0] rsp_rd,
  output logic [XLEN-1:0]   rsp_pc,
  output logic              rsp_exc_en,
  output logic [3:0]        rsp_exc_code,
  output logic [XLEN-1:0]   rsp_exc_val
);

  // Stage A
  logic              r_a_valid;
  logic              r_a_is_load;
  logic              r_a_is_store;
  logic [2:0]        r_a_funct3;
  logic [XLEN-1:0]   r_a_addr;
  logic [XLEN-1:0]   r_a_wdata;
  logic [REG_AW-1:0] r_a_rd;
  logic [XLEN-1:0]   r_a_pc;

  // Stage B
  logic              r_b_valid;
  logic              r_b_wb_en;
  logic              r_b_exc;
  logic [3:0]        r_b_exc_code;
  logic [XLEN-1:0]   r_b_exc_val;
  logic [XLEN-1:0]   r_b_rdata;
  logic [REG_AW-1:0] r_b_rd;
  logic [XLEN-1:0]   r_b_pc;

  // Pipeline control
  logic              w_b_free;
  logic              w_a_adv;
  logic              w_accept;
  logic              w_a_illegal;

  // Stage B capture values
  logic [XLEN-1:0]   w_fmt_data;
  logic              w_cap_exc;
  logic [3:0]        w_cap_code;
  logic [XLEN-1:0]   w_cap_val;
  logic [XLEN-1:0]   w_cap_rdata;
  logic              w_cap_wb_en;

  assign w_b_free    = !r_b_valid || rsp_ready;
  assign w_a_adv     = r_a_valid && w_b_free && !flush;
  assign req_ready   = !r_a_valid || w_b_free;
  assign w_accept    = req_valid && req_ready && !flush;
  assign w_a_illegal = f3_illegal(r_a_is_load, r_a_is_store, r_a_funct3);

  // dmem side: an illegal encoding never reaches memory, and a store only
  // writes on the edge where it leaves stage A, so stalls and flushes
  // cannot double-commit or commit a cancelled store.
  assign is_LOAD       = r_a_valid && r_a_is_load && !w_a_illegal;
  assign we_dmem       = w_a_adv && r_a_is_store && !w_a_illegal;
  assign dmem_word_sel = r_a_valid ? sel_from_size(r_a_funct3[1:0]) : 8'h00;
  assign r_dmem_addr   = r_a_valid ? r_a_addr  : '0;
  assign w_dmem_data   = r_a_valid ? r_a_wdata : '0;

  lsu_load_fmt #(
    .XLEN (XLEN)
  ) u_load_fmt (
    .i_funct3 (r_a_funct3),
    .i_data   (dmem_data),
    .o_data   (w_fmt_data)
  );

  // Build the response that stage B captures when stage A advances
  always_comb begin
    w_cap_exc   = 1'b0;
    w_cap_code  = 4'd0;
    w_cap_val   = '0;
    w_cap_rdata = '0;
    w_cap_wb_en = 1'b0;
    if (w_a_illegal) begin
      w_cap_exc  = 1'b1;
      w_cap_code = EXC_ILLEGAL;
    end else if (dmem_exc_en) begin
      w_cap_exc  = 1'b1;
      w_cap_code = dmem_exc_code;
      w_cap_val  = dmem_exc_val;
    end
    if (r_a_is_load && !w_cap_exc) begin
      w_cap_rdata = w_fmt_data;
      w_cap_wb_en = (r_a_rd != '0);
    end
  end

  // Stage A register: load on accept, empty when it drains with no refill
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_valid    <= 1'b0;
      r_a_is_load  <= 1'b0;
      r_a_is_store <= 1'b0;
      r_a_funct3   <= 3'd0;
      r_a_addr     <= '0;
      r_a_wdata    <= '0;
      r_a_rd       <= '0;
      r_a_pc       <= '0;
    end else if (flush) begin
      r_a_valid <= 1'b0;
    end else if (w_accept) begin
      r_a_valid    <= 1'b1;
      r_a_is_load  <= req_is_load;
      r_a_is_store <= req_is_store;
      r_a_funct3   <= req_funct3;
      r_a_addr     <= req_addr;
      r_a_wdata    <= req_wdata;
      r_a_rd       <= req_rd;
      r_a_pc       <= req_pc;
    end else if (w_a_adv) begin
      r_a_valid <= 1'b0;
    end
  end

  // Stage B register: replaced on advance (no bubble even while the
  // consumer takes the old response), emptied when consumed with no refill
  always_ff @(posedge clk) begin
    if (rst) begin
      r_b_valid    <= 1'b0;
      r_b_wb_en    <= 1'b0;
      r_b_exc      <= 1'b0;
      r_b_exc_code <= 4'd0;
      r_b_exc_val  <= '0;
      r_b_rdata    <= '0;
      r_b_rd       <= '0;
      r_b_pc       <= '0;
    end else if (flush) begin
      r_b_valid <= 1'b0;
    end else if (w_a_adv) begin
      r_b_valid    <= 1'b1;
      r_b_wb_en    <= w_cap_wb_en;
      r_b_exc      <= w_cap_exc;
      r_b_exc_code <= w_cap_code;
      r_b_exc_val  <= w_cap_val;
      r_b_rdata    <= w_cap_rdata;
      r_b_rd       <= r_a_rd;
      r_b_pc       <= r_a_pc;
    end else if (rsp_ready) begin
      r_b_valid <= 1'b0;
    end
  end

  assign rsp_valid    = r_b_valid;
  assign rsp_wb_en    = r_b_valid && r_b_wb_en;
  assign rsp_exc_en   = r_b_valid && r_b_exc;
  assign rsp_exc_code = r_b_exc_code;
  assign rsp_exc_val  = r_b_exc_val;
  assign rsp_rdata    = r_b_rdata;
  assign rsp_rd       = r_b_rd;
  assign rsp_pc       = r_b_pc;

endmodule
